// File: rtl/uart_rx_monitor.sv
// UART receiver with configurable framing, a first-word fall-through frame FIFO
// and sticky frame/parity/overrun error flags, all on core_clk.
module uart_rx_monitor #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                              core_clk,
    input  logic                              core_rstn,
    input  logic                              ser_rx,
    input  logic                              rd_en,
    input  logic                              err_clr,
    output logic [DATA_BITS-1:0]              rd_data,
    output logic                              rd_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              frame_err,
    output logic                              parity_err,
    output logic                              overrun_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = 4;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int FCW   = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] HALF_END  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic [FCW-1:0]   FULL_CNT  = FCW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        BRK
    } state_t;

    state_t state_q, state_d;

    logic                 rx_meta, rx_s, rx_prev;
    logic [CNT_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_bad_q;
    logic                 push_req_q;
    logic [DATA_BITS-1:0] push_data_q;
    logic                 push_par_q;

    logic cnt_clr, idx_clr, idx_inc, shift_en, par_en, frame_bad, frame_ok;
    logic tick_half, tick_bit;

    // Two-flop synchroniser plus one delayed copy for start-edge detection.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= ser_rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign tick_half = (cnt_q == HALF_END);
    assign tick_bit  = (cnt_q == BIT_END);

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_clr   = 1'b0;
        idx_clr   = 1'b0;
        idx_inc   = 1'b0;
        shift_en  = 1'b0;
        par_en    = 1'b0;
        frame_bad = 1'b0;
        frame_ok  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rx_prev && !rx_s) begin
                    cnt_clr = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (tick_half) begin
                    cnt_clr = 1'b1;
                    idx_clr = 1'b1;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick_bit) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (idx_q == DATA_LAST) begin
                        idx_clr = 1'b1;
                        state_d = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end
            PAR: begin
                if (tick_bit) begin
                    cnt_clr = 1'b1;
                    par_en  = 1'b1;
                    idx_clr = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick_bit) begin
                    cnt_clr = 1'b1;
                    if (!rx_s) begin
                        frame_bad = 1'b1;
                        state_d   = BRK;
                    end else if (idx_q == STOP_LAST) begin
                        frame_ok = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end
            BRK: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            par_bad_q <= 1'b0;
        end else begin
            cnt_q <= cnt_clr ? '0 : cnt_q + 1'b1;
            if (idx_clr)      idx_q <= '0;
            else if (idx_inc) idx_q <= idx_q + 1'b1;
            if (shift_en) shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
            if (state_q == START) par_bad_q <= 1'b0;
            else if (par_en)      par_bad_q <= (PARITY == 1) ? ~(^{shift_q, rx_s}) : (^{shift_q, rx_s});
        end
    end

    // The frame is staged for one cycle; the FIFO write happens while the FSM is already in IDLE.
    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            push_req_q  <= 1'b0;
            push_data_q <= '0;
            push_par_q  <= 1'b0;
        end else begin
            push_req_q <= frame_ok;
            if (frame_ok) begin
                push_data_q <= shift_q;
                push_par_q  <= par_bad_q;
            end
        end
    end

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [FCW-1:0]       count_q;
    logic                 full, pop, do_push;

    assign full    = (count_q == FULL_CNT);
    assign pop     = rd_en && rd_valid;
    assign do_push = push_req_q && (!full || pop);

    // NOTE: storage has no reset; rd_data is masked while empty instead.
    always_ff @(posedge core_clk) begin
        if (do_push) mem[wr_ptr] <= push_data_q;
    end

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rd_valid   = (count_q != '0);
    assign rd_data    = rd_valid ? mem[rd_ptr] : '0;
    assign fifo_count = count_q;

    // A fresh error event in the same cycle as err_clr keeps its flag set.
    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (frame_bad)    frame_err <= 1'b1;
            else if (err_clr) frame_err <= 1'b0;
            if (push_req_q && push_par_q) parity_err <= 1'b1;
            else if (err_clr)             parity_err <= 1'b0;
            if (push_req_q && full && !pop) overrun_err <= 1'b1;
            else if (err_clr)               overrun_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Scoreboard bench for uart_rx_monitor: an 8N1 instance and an 8E1 instance.
module tb_uart_rx_monitor;

    localparam int CPB = 16;

    logic core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    logic       core_rstn;
    logic       ser_rx, rd_en, err_clr;
    logic [7:0] rd_data;
    logic       rd_valid, frame_err, parity_err, overrun_err;
    logic [2:0] fifo_count;

    logic       ser_rx_p, rd_en_p, err_clr_p;
    logic [7:0] rd_data_p;
    logic       rd_valid_p, frame_err_p, parity_err_p, overrun_err_p;
    logic [2:0] fifo_count_p;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q [$];
    logic [7:0] exp_qp[$];

    uart_rx_monitor #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
        .core_clk(core_clk), .core_rstn(core_rstn), .ser_rx(ser_rx), .rd_en(rd_en), .err_clr(err_clr),
        .rd_data(rd_data), .rd_valid(rd_valid), .fifo_count(fifo_count),
        .frame_err(frame_err), .parity_err(parity_err), .overrun_err(overrun_err)
    );

    uart_rx_monitor #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_p (
        .core_clk(core_clk), .core_rstn(core_rstn), .ser_rx(ser_rx_p), .rd_en(rd_en_p), .err_clr(err_clr_p),
        .rd_data(rd_data_p), .rd_valid(rd_valid_p), .fifo_count(fifo_count_p),
        .frame_err(frame_err_p), .parity_err(parity_err_p), .overrun_err(overrun_err_p)
    );

    task automatic drive_bit(input int sel, input logic v, input int cycles);
        if (sel == 0) ser_rx = v;
        else          ser_rx_p = v;
        repeat (cycles) @(negedge core_clk);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input bit use_par,
                              input logic par_bit, input logic stop_val);
        @(negedge core_clk);
        drive_bit(sel, 1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i], CPB);
        if (use_par) drive_bit(sel, par_bit, CPB);
        drive_bit(sel, stop_val, CPB);
        if (!stop_val) drive_bit(sel, 1'b1, CPB);
        repeat (2) @(negedge core_clk);
    endtask

    task automatic pulse_clr(input int sel);
        @(negedge core_clk);
        if (sel == 0) err_clr = 1'b1; else err_clr_p = 1'b1;
        @(negedge core_clk);
        err_clr   = 1'b0;
        err_clr_p = 1'b0;
    endtask

    task automatic pop_check(input int sel, input string name);
        int         t;
        logic [7:0] exp;
        logic [7:0] got;
        t = 0;
        @(negedge core_clk);
        while (!(sel != 0 ? rd_valid_p : rd_valid) && t < 300) begin
            @(negedge core_clk);
            t++;
        end
        checks++;
        if (t >= 300) begin
            failures++;
            $display("FAIL %s: rd_valid got 0 expected 1 (timeout)", name);
        end else begin
            exp = (sel != 0) ? exp_qp.pop_front() : exp_q.pop_front();
            got = (sel != 0) ? rd_data_p : rd_data;
            if (got !== exp) begin
                failures++;
                $display("FAIL %s: rd_data got %h expected %h", name, got, exp);
            end
            if (sel == 0) rd_en = 1'b1; else rd_en_p = 1'b1;
            @(negedge core_clk);
            rd_en   = 1'b0;
            rd_en_p = 1'b0;
        end
    endtask

    task automatic test_reset();
        core_rstn = 1'b0;
        ser_rx = 1'b1; ser_rx_p = 1'b1;
        rd_en = 1'b0; rd_en_p = 1'b0; err_clr = 1'b0; err_clr_p = 1'b0;
        repeat (3) @(negedge core_clk);
        checks++; if (rd_valid !== 1'b0)      begin failures++; $display("FAIL reset_valid: got %b expected 0", rd_valid); end
        checks++; if (rd_data !== 8'h00)      begin failures++; $display("FAIL reset_data: got %h expected 00", rd_data); end
        checks++; if (fifo_count !== 3'd0)    begin failures++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        checks++; if ({frame_err, parity_err, overrun_err} !== 3'b000)
            begin failures++; $display("FAIL reset_flags: got %b expected 000", {frame_err, parity_err, overrun_err}); end
        checks++; if ({rd_valid_p, parity_err_p, fifo_count_p} !== 5'd0)
            begin failures++; $display("FAIL reset_p: got %b expected 0", {rd_valid_p, parity_err_p, fifo_count_p}); end
        core_rstn = 1'b1;
        repeat (4) @(negedge core_clk);
    endtask

    task automatic test_basic();
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        exp_q.push_back(8'hA5);
        checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL basic_count: got %0d expected 1", fifo_count); end
        checks++; if (rd_valid !== 1'b1)   begin failures++; $display("FAIL basic_valid: got %b expected 1", rd_valid); end
        checks++; if ({frame_err, parity_err, overrun_err} !== 3'b000)
            begin failures++; $display("FAIL basic_flags: got %b expected 000", {frame_err, parity_err, overrun_err}); end
        pop_check(0, "basic_data");
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL basic_empty: got %0d expected 0", fifo_count); end
    endtask

    task automatic test_parity();
        // 0x3C has even weight, so an even-parity bit of 1 is wrong.
        send_frame(1, 8'h3C, 1'b1, 1'b1, 1'b1);
        exp_qp.push_back(8'h3C);
        checks++; if (parity_err_p !== 1'b1)   begin failures++; $display("FAIL par_err_set: got %b expected 1", parity_err_p); end
        checks++; if (fifo_count_p !== 3'd1)   begin failures++; $display("FAIL par_count: got %0d expected 1", fifo_count_p); end
        pop_check(1, "par_bad_data");
        pulse_clr(1);
        checks++; if (parity_err_p !== 1'b0)   begin failures++; $display("FAIL par_err_clr: got %b expected 0", parity_err_p); end
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
        exp_qp.push_back(8'h07);
        checks++; if (parity_err_p !== 1'b0)   begin failures++; $display("FAIL par_good: got %b expected 0", parity_err_p); end
        pop_check(1, "par_good_data");
    endtask

    task automatic test_frame_err();
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
        checks++; if (frame_err !== 1'b1)  begin failures++; $display("FAIL ferr_set: got %b expected 1", frame_err); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL ferr_nopush: got %0d expected 0", fifo_count); end
        send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1);
        exp_q.push_back(8'h12);
        pop_check(0, "ferr_recover");
        pulse_clr(0);
        checks++; if (frame_err !== 1'b0)  begin failures++; $display("FAIL ferr_clr: got %b expected 0", frame_err); end
    endtask

    task automatic test_overrun();
        for (int v = 1; v <= 5; v++) begin
            send_frame(0, 8'(v), 1'b0, 1'b0, 1'b1);
            if (v <= 4) exp_q.push_back(8'(v));
        end
        checks++; if (fifo_count !== 3'd4)  begin failures++; $display("FAIL ovr_count: got %0d expected 4", fifo_count); end
        checks++; if (overrun_err !== 1'b1) begin failures++; $display("FAIL ovr_flag: got %b expected 1", overrun_err); end
        for (int i = 0; i < 4; i++) pop_check(0, "ovr_pop");
        checks++; if (rd_valid !== 1'b0)    begin failures++; $display("FAIL ovr_empty: got %b expected 0", rd_valid); end
        pulse_clr(0);
        checks++; if (overrun_err !== 1'b0) begin failures++; $display("FAIL ovr_clr: got %b expected 0", overrun_err); end
    endtask

    task automatic test_glitch();
        @(negedge core_clk);
        drive_bit(0, 1'b0, 4);
        drive_bit(0, 1'b1, 3 * CPB);
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL glitch_nopush: got %0d expected 0", fifo_count); end
        checks++; if ({frame_err, parity_err, overrun_err} !== 3'b000)
            begin failures++; $display("FAIL glitch_flags: got %b expected 000", {frame_err, parity_err, overrun_err}); end
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
        exp_q.push_back(8'h5A);
        pop_check(0, "glitch_recover");
    endtask

    task automatic test_reset_mid();
        send_frame(0, 8'h77, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h33, 1'b0, 1'b0, 1'b0);
        checks++; if ({fifo_count, frame_err} !== 4'b0011)
            begin failures++; $display("FAIL rmid_pre: got %b expected 0011", {fifo_count, frame_err}); end
        @(negedge core_clk);
        drive_bit(0, 1'b0, CPB);
        for (int i = 0; i < 3; i++) drive_bit(0, 1'b1, CPB);
        drive_bit(0, 1'b1, CPB / 2);
        core_rstn = 1'b0;
        #1;
        checks++; if ({rd_valid, fifo_count, rd_data} !== 12'h000)
            begin failures++; $display("FAIL rmid_fifo: got %h expected 000", {rd_valid, fifo_count, rd_data}); end
        checks++; if ({frame_err, parity_err, overrun_err} !== 3'b000)
            begin failures++; $display("FAIL rmid_flags: got %b expected 000", {frame_err, parity_err, overrun_err}); end
        repeat (3) @(negedge core_clk);
        core_rstn = 1'b1;
        repeat (2 * CPB) @(negedge core_clk);
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
        exp_q.push_back(8'h81);
        pop_check(0, "rmid_recover");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_frame_err();
        test_overrun();
        test_glitch();
        test_reset_mid();
        repeat (4) @(negedge core_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
